// File: rtl/satd_abs_accumulator.sv
// SATD accumulator: takes rows of four signed vertical-Hadamard coefficients, sums their magnitudes
// over a 4x4 block and reports the block SATD. Define SATD_HALVE_EN to report the rounded half instead.
module satd_abs_accumulator #(
  parameter int COEF_W = 13,
  parameter int ACC_W  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_absolute,
  input  logic                  enable_sum,
  input  logic                  end_sum_flag,
  input  logic [4*COEF_W-1:0]   coef_in,
  output logic [ACC_W-1:0]      satd_out,
  output logic                  satd_valid,
  output logic                  row_error,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [COEF_W-1:0]   r_abs [4];
  logic                r_abs_valid;
  logic [ACC_W-1:0]    r_acc;
  logic [2:0]          r_row_cnt;
  logic                r_extra_row;
  logic [ACC_W-1:0]    r_satd_out;
  logic                r_satd_valid;
  logic                r_row_error;

  logic [COEF_W+1:0]   w_row_sum;
  logic                w_row_in;
  logic                w_accept;
  logic                w_extra;
  logic [ACC_W-1:0]    w_result;

  // The most negative coefficient negates to 2^(COEF_W-1), which still fits as an unsigned COEF_W value.
  function automatic logic [COEF_W-1:0] abs_coef(input logic [COEF_W-1:0] c);
    return c[COEF_W-1] ? (~c + COEF_W'(1)) : c;
  endfunction

  // Stage A: register the magnitudes of the incoming row.
  // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_abs_valid <= 1'b0;
      // NOTE: only four small registers, so clearing them costs nothing and keeps reset state fully defined.
      for (int i = 0; i < 4; i++) r_abs[i] <= '0;
    end else begin
      r_abs_valid <= enable_absolute;
      if (enable_absolute) begin
        for (int i = 0; i < 4; i++) r_abs[i] <= abs_coef(coef_in[i*COEF_W +: COEF_W]);
      end
    end
  end

  assign w_row_sum = (COEF_W+2)'(r_abs[0]) + (COEF_W+2)'(r_abs[1])
                   + (COEF_W+2)'(r_abs[2]) + (COEF_W+2)'(r_abs[3]);
  assign w_row_in  = r_abs_valid & enable_sum;
  assign w_accept  = w_row_in & (r_row_cnt < 3'd4);
  assign w_extra   = w_row_in & (r_row_cnt == 3'd4);

`ifdef SATD_HALVE_EN
  assign w_result = ACC_W'(({1'b0, r_acc} + (ACC_W+1)'(1)) >> 1);
`else
  assign w_result = r_acc;
`endif

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next_state = ACCUM;
      ACCUM:   if (end_sum_flag && !r_abs_valid) w_next_state = DONE;
      // A row arriving during DONE opens the next block immediately.
      DONE:    w_next_state = w_row_in ? ACCUM : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Stage B and block close-out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_row_cnt    <= '0;
      r_extra_row  <= 1'b0;
      r_satd_out   <= '0;
      r_satd_valid <= 1'b0;
      r_row_error  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_satd_valid <= 1'b0;
      r_row_error  <= 1'b0;
      if (r_state == DONE) begin
        r_satd_out   <= w_result;
        r_satd_valid <= 1'b1;
        r_row_error  <= (r_row_cnt != 3'd4) | r_extra_row;
        r_extra_row  <= 1'b0;
        if (w_row_in) begin
          r_acc     <= ACC_W'(w_row_sum);
          r_row_cnt <= 3'd1;
        end else begin
          r_acc     <= '0;
          r_row_cnt <= '0;
        end
      end else begin
        if (w_accept) begin
          r_acc     <= r_acc + ACC_W'(w_row_sum);
          r_row_cnt <= r_row_cnt + 3'd1;
        end
        if (w_extra) r_extra_row <= 1'b1;
      end
    end
  end

  assign satd_out   = r_satd_out;
  assign satd_valid = r_satd_valid;
  assign row_error  = r_row_error;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_satd_abs_accumulator.sv
// Self-checking bench for satd_abs_accumulator: directed corner blocks plus random blocks
// checked against a row-level model of the SATD rules.
module tb_satd_abs_accumulator;

  localparam int COEF_W = 13;
  localparam int ACC_W  = 17;

  logic                clk;
  logic                reset;
  logic                enable_absolute;
  logic                enable_sum;
  logic                end_sum_flag;
  logic [4*COEF_W-1:0] coef_in;
  logic [ACC_W-1:0]    satd_out;
  logic                satd_valid;
  logic                row_error;
  logic                busy;

  satd_abs_accumulator #(.COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_absolute (enable_absolute),
    .enable_sum      (enable_sum),
    .end_sum_flag    (end_sum_flag),
    .coef_in         (coef_in),
    .satd_out        (satd_out),
    .satd_valid      (satd_valid),
    .row_error       (row_error),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int sum;
    bit err;
  } result_t;

  result_t obs_q[$];
  int      stray_row_error;
  int      n_checks;
  int      n_pass;

  // Reference model state for the block being built.
  int      m_sum;
  int      m_rows;
  bit      m_extra;
  bit      prev_es;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (satd_valid) begin
      result_t r;
      r.sum = int'(satd_out);
      r.err = row_error;
      obs_q.push_back(r);
    end else if (row_error) begin
      stray_row_error++;
    end
  end

  function automatic int expect_out(input int s);
`ifdef SATD_HALVE_EN
    return (s + 1) / 2;
`else
    return s;
`endif
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear();
    m_sum   = 0;
    m_rows  = 0;
    m_extra = 0;
  endtask

  // One clock: enable_sum is the decision for the row presented on the previous cycle.
  task automatic cycle(input bit ea, input logic [4*COEF_W-1:0] coef, input bit es);
    enable_absolute = ea;
    coef_in         = coef;
    enable_sum      = prev_es;
    prev_es         = es;
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input int c0, input int c1, input int c2, input int c3, input bit es);
    logic [4*COEF_W-1:0] packed_row;
    packed_row = {COEF_W'(c3), COEF_W'(c2), COEF_W'(c1), COEF_W'(c0)};
    if (es) begin
      if (m_rows < 4) begin
        m_sum  += iabs(c0) + iabs(c1) + iabs(c2) + iabs(c3);
        m_rows += 1;
      end else begin
        m_extra = 1;
      end
    end
    cycle(1'b1, packed_row, es);
  endtask

  // Raise end_sum_flag together with the last row's enable_sum and hold it until the result appears.
  task automatic end_block(input string tag);
    int n0;
    int waited;
    int exp_sum;
    bit exp_err;
    n0      = obs_q.size();
    exp_sum = expect_out(m_sum);
    exp_err = (m_rows != 4) || m_extra;
    end_sum_flag = 1'b1;
    waited = 0;
    while (obs_q.size() == n0 && waited < 12) begin
      cycle(1'b0, '0, 1'b1);
      waited++;
    end
    end_sum_flag = 1'b0;
    repeat (3) cycle(1'b0, '0, 1'b1);
    if (m_rows == 0) begin
      check({tag, "_no_pulse"}, obs_q.size() - n0, 0);
    end else begin
      check({tag, "_pulses"}, obs_q.size() - n0, 1);
      if (obs_q.size() > n0) begin
        check({tag, "_sum"}, obs_q[n0].sum, exp_sum);
        check({tag, "_err"}, obs_q[n0].err, exp_err);
      end
      check({tag, "_hold"}, satd_out, exp_sum);
      check({tag, "_idle"}, busy, 0);
    end
    obs_q.delete();
    model_clear();
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    enable_absolute = 1'b0;
    enable_sum      = 1'b0;
    end_sum_flag    = 1'b0;
    prev_es         = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks        = 0;
    n_pass          = 0;
    stray_row_error = 0;
    coef_in         = '0;
    apply_reset();
    check("rst_satd_out", satd_out, 0);
    check("rst_satd_valid", satd_valid, 0);
    check("rst_row_error", row_error, 0);
    check("rst_busy", busy, 0);

    // Four rows of {1,-2,3,-4}; busy rises once the first row is accepted.
    send_row(1, -2, 3, -4, 1'b1);
    cycle(1'b0, '0, 1'b1);
    check("busy_accum", busy, 1);
    repeat (3) send_row(1, -2, 3, -4, 1'b1);
    end_block("mixed_sign");

    // Most negative coefficient everywhere: 16 * 4096 = 65536.
    repeat (4) send_row(-4096, -4096, -4096, -4096, 1'b1);
    end_block("most_neg");

    repeat (3) send_row(5, 5, 5, 5, 1'b1);
    end_block("three_rows");

    repeat (5) send_row(1, 1, 1, 1, 1'b1);
    end_block("five_rows");

    // A row with enable_sum low is discarded without counting.
    send_row(2, 0, 0, 0, 1'b1);
    send_row(100, 100, 100, 100, 1'b0);
    repeat (3) send_row(2, 0, 0, 0, 1'b1);
    end_block("end_with_last");

    // Reset abandons a partial block.
    send_row(7, 7, 7, 7, 1'b1);
    send_row(7, 7, 7, 7, 1'b1);
    apply_reset();
    repeat (2) cycle(1'b0, '0, 1'b1);
    check("rst_no_pulse", obs_q.size(), 0);
    check("rst_clear_out", satd_out, 0);
    check("rst_clear_busy", busy, 0);
    repeat (4) send_row(1, 0, 0, 0, 1'b1);
    end_block("after_reset");
    end_block("idle_end");

    for (int b = 0; b < 12; b++) begin
      int nrows;
      nrows = $urandom_range(0, 6);
      for (int r = 0; r < nrows; r++) begin
        int c [4];
        bit es;
        for (int i = 0; i < 4; i++) c[i] = int'($urandom_range(0, 8191)) - 4096;
        es = (m_rows < 4) ? ($urandom_range(0, 9) != 0) : 1'b1;
        send_row(c[0], c[1], c[2], c[3], es);
        if ($urandom_range(0, 3) == 0) cycle(1'b0, '0, 1'b1);
      end
      end_block($sformatf("rand%0d", b));
    end

    check("row_error_stray", stray_row_error, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
